// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per RUN cycle,
// with a single-cycle bypass that flags a zero divisor.
module div8_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] X,
    input  logic [7:0] Y,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       busy,
    output logic       done,
    output logic       dbz
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] dvd_q, dvd_d;   // dividend shifts out, quotient bits shift in
    logic [7:0] dvs_q, dvs_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] q_q, q_d;
    logic [7:0] r_q, r_d;
    logic       dbz_q, dbz_d;

    logic [8:0] shifted;
    logic [8:0] trial;
    logic       qbit;
    logic [7:0] rem_next;
    logic [7:0] dvd_next;

    // One restoring step; bit 8 of the 9-bit difference is the borrow.
    always_comb begin
        shifted  = {rem_q, dvd_q[7]};
        trial    = shifted - {1'b0, dvs_q};
        qbit     = ~trial[8];
        rem_next = qbit ? trial[7:0] : shifted[7:0];
        dvd_next = {dvd_q[6:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvd_d = X;
                    dvs_d = Y;
                    rem_d = 8'd0;
                    cnt_d = 3'd0;
                    if (Y == 8'd0) begin
                        state_d = StDone;
                        q_d     = 8'hFF;
                        r_d     = X;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                rem_d = rem_next;
                dvd_d = dvd_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
                    q_d     = dvd_next;
                    r_d     = rem_next;
                    dbz_d   = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            dvd_q   <= 8'd0;
            dvs_q   <= 8'd0;
            rem_q   <= 8'd0;
            q_q     <= 8'd0;
            r_q     <= 8'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign dbz  = dbz_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_div8_seq.sv
// Directed and randomised self-checking bench for div8_seq: latency, handshake,
// zero-divisor bypass, start filtering and reset abort.
module tb_div8_seq;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] X;
    logic [7:0] Y;
    logic [7:0] Q;
    logic [7:0] R;
    logic       busy;
    logic       done;
    logic       dbz;

    int tests_run;
    int tests_failed;

    // Bench-side record of what Q/R/dbz must hold between DONE entries.
    logic [7:0] prev_q;
    logic [7:0] prev_r;
    logic       prev_dbz;

    div8_seq dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .X      (X),
        .Y      (Y),
        .Q      (Q),
        .R      (R),
        .busy   (busy),
        .done   (done),
        .dbz    (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one division and check every cycle until the IDLE cycle after done.
    task automatic run_div(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] eq, input logic [7:0] er, input logic edbz);
        @(negedge clk);
        start = 1'b1;
        X     = x;
        Y     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        X     = ~x;
        Y     = ~y;
        if (y != 8'd0) begin
            for (int e = 1; e <= 8; e++) begin
                check_eq({tag, " busy"}, {31'd0, busy}, 32'd1);
                check_eq({tag, " early done"}, {31'd0, done}, 32'd0);
                if (e == 4) begin
                    check_eq({tag, " Q hold"}, {24'd0, Q}, {24'd0, prev_q});
                    check_eq({tag, " R hold"}, {24'd0, R}, {24'd0, prev_r});
                    check_eq({tag, " dbz hold"}, {31'd0, dbz}, {31'd0, prev_dbz});
                end
                @(posedge clk);
                #1;
            end
        end
        check_eq({tag, " done"}, {31'd0, done}, 32'd1);
        check_eq({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " Q"}, {24'd0, Q}, {24'd0, eq});
        check_eq({tag, " R"}, {24'd0, R}, {24'd0, er});
        check_eq({tag, " dbz"}, {31'd0, dbz}, {31'd0, edbz});
        @(posedge clk);
        #1;
        check_eq({tag, " done pulse"}, {31'd0, done}, 32'd0);
        check_eq({tag, " Q after"}, {24'd0, Q}, {24'd0, eq});
        prev_q   = eq;
        prev_r   = er;
        prev_dbz = edbz;
    endtask

    initial begin
        int done_cnt;
        logic [7:0] rx;
        logic [7:0] ry;

        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        X            = 8'd0;
        Y            = 8'd0;
        prev_q       = 8'd0;
        prev_r       = 8'd0;
        prev_dbz     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst Q", {24'd0, Q}, 32'd0);
        check_eq("rst R", {24'd0, R}, 32'd0);
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst done", {31'd0, done}, 32'd0);
        check_eq("rst dbz", {31'd0, dbz}, 32'd0);

        // Start while reset is asserted must be ignored.
        @(negedge clk);
        start = 1'b1;
        X     = 8'd9;
        Y     = 8'd3;
        @(posedge clk);
        #1;
        start   = 1'b0;
        reset_n = 1'b1;
        check_eq("rst start busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst start busy2", {31'd0, busy}, 32'd0);
        check_eq("rst start done", {31'd0, done}, 32'd0);

        // Back-to-back directed vectors.
        run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        run_div("d200_0", 8'd200, 8'd0, 8'hFF, 8'd200, 1'b1);
        run_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        run_div("d254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0);
        run_div("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
        run_div("d0_0", 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1);
        run_div("d128_2", 8'd128, 8'd2, 8'd64, 8'd0, 1'b0);

        // Restart attempt mid-run with inputs toggling: ignored, one done pulse.
        @(negedge clk);
        start = 1'b1;
        X     = 8'd100;
        Y     = 8'd7;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (e == 3) begin
                start = 1'b1;
                X     = 8'd50;
                Y     = 8'd5;
            end else begin
                start = 1'b0;
                X     = 8'($urandom);
                Y     = 8'($urandom);
            end
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (e == 8) begin
                check_eq("ovl done", {31'd0, done}, 32'd1);
                check_eq("ovl Q", {24'd0, Q}, 32'd14);
                check_eq("ovl R", {24'd0, R}, 32'd2);
            end
        end
        start = 1'b0;
        check_eq("ovl pulses", done_cnt, 32'd1);
        check_eq("ovl busy end", {31'd0, busy}, 32'd0);
        prev_q   = 8'd14;
        prev_r   = 8'd2;
        prev_dbz = 1'b0;

        // Reset at E4 of a running division.
        @(negedge clk);
        start = 1'b1;
        X     = 8'd100;
        Y     = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort busy", {31'd0, busy}, 32'd0);
        check_eq("abort done", {31'd0, done}, 32'd0);
        check_eq("abort Q", {24'd0, Q}, 32'd0);
        check_eq("abort R", {24'd0, R}, 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        done_cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        check_eq("abort no done", done_cnt, 32'd0);
        prev_q   = 8'd0;
        prev_r   = 8'd0;
        prev_dbz = 1'b0;

        // Randomised runs against a reference model.
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom_range(255, 1));
            run_div("rand", rx, ry, rx / ry, rx % ry, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d checks, expected completion", tests_run);
        $fatal(1, "timeout");
    end

endmodule
